// File: rtl/q_frag_regstage_if.sv
`default_nettype none
// ============================================================================
// q_frag_regstage_if : cell-side signal bundle of the Q_FRAG register stage.
//                      Config-chain signals exist only with Q_FRAG_CFG_CHAIN_EN.
// Revision           : 1.0
// ============================================================================
interface q_frag_regstage_if;
    logic QST;
    logic QEN;
    logic QDS;
    logic CZ;
    logic QDI;
    logic QZ;
`ifdef Q_FRAG_CFG_CHAIN_EN
    logic CFG_SI;
    logic CFG_SE;
    logic CFG_LD;
    logic CFG_SO;
    logic CFG_RDY;
    logic CFG_ERR;

    modport master (
        output QST, QEN, QDS, CZ, QDI,
        input  QZ,
        output CFG_SI, CFG_SE, CFG_LD,
        input  CFG_SO, CFG_RDY, CFG_ERR
    );

    modport slave (
        input  QST, QEN, QDS, CZ, QDI,
        output QZ,
        input  CFG_SI, CFG_SE, CFG_LD,
        output CFG_SO, CFG_RDY, CFG_ERR
    );
`else
    modport master (
        output QST, QEN, QDS, CZ, QDI,
        input  QZ
    );

    modport slave (
        input  QST, QEN, QDS, CZ, QDI,
        output QZ
    );
`endif
endinterface
`default_nettype wire

// File: rtl/q_frag_regstage.sv
`default_nettype none
// ============================================================================
// q_frag_regstage : PP3 logic-cell register stage driving QZ, with a 4-bit
//                   mode word. Q_FRAG_CFG_CHAIN_EN adds the serial config chain
//                   (shadow/active double buffer); otherwise mode = CFG_DEFAULT.
// Revision        : 1.0
// ============================================================================
module q_frag_regstage #(
    parameter int unsigned      CFG_W       = 4,
    parameter logic [CFG_W-1:0] CFG_DEFAULT = '0
) (
    input  logic             QCK,
    input  logic             QRT,
    q_frag_regstage_if.slave q
);

    localparam int unsigned B_FORCE_QDI = 0;
    localparam int unsigned B_EN_INV    = 1;
    localparam int unsigned B_SR_SWAP   = 2;
    localparam int unsigned B_BYPASS    = 3;

    logic [CFG_W-1:0] w_mode;
    logic             w_force_qdi;
    logic             w_en_inv;
    logic             w_sr_swap;
    logic             w_bypass;
    logic             w_d;
    logic             w_en;
    logic             r_ff;

`ifdef Q_FRAG_CFG_CHAIN_EN
    localparam int unsigned            C_CNT_W    = $clog2(CFG_W + 1);
    localparam logic [C_CNT_W-1:0]     C_CNT_FULL = C_CNT_W'(CFG_W);
    localparam logic [C_CNT_W-1:0]     C_CNT_ONE  = C_CNT_W'(1);

    logic [CFG_W-1:0]   r_shadow;
    logic [CFG_W-1:0]   r_active;
    logic [C_CNT_W-1:0] r_count;
    logic               r_err;
    logic               w_full;

    assign w_full = (r_count == C_CNT_FULL);

    // A load copies the shadow as it stood before this edge's shift, so a
    // simultaneous shift+load leaves exactly one fresh bit counted.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            r_shadow <= CFG_DEFAULT;
            r_active <= CFG_DEFAULT;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (q.CFG_SE) begin
                r_shadow <= {r_shadow[CFG_W-2:0], q.CFG_SI};
            end
            if (q.CFG_LD && w_full) begin
                r_active <= r_shadow;
                r_count  <= q.CFG_SE ? C_CNT_ONE : '0;
            end else begin
                if (q.CFG_LD) begin
                    r_err <= 1'b1;
                end
                if (q.CFG_SE && !w_full) begin
                    r_count <= r_count + C_CNT_ONE;
                end
            end
        end
    end

    assign w_mode    = r_active;
    assign q.CFG_SO  = r_shadow[CFG_W-1];
    assign q.CFG_RDY = w_full;
    assign q.CFG_ERR = r_err;
`else
    assign w_mode = CFG_DEFAULT;
`endif

    assign w_force_qdi = w_mode[B_FORCE_QDI];
    assign w_en_inv    = w_mode[B_EN_INV];
    assign w_sr_swap   = w_mode[B_SR_SWAP];
    assign w_bypass    = w_mode[B_BYPASS];

    assign w_d  = (w_force_qdi | q.QDS) ? q.QDI : q.CZ;
    assign w_en = q.QEN ^ w_en_inv;

    // Reset/set use the mode in force before this edge; the config reset on
    // the same edge only affects later edges.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            r_ff <= w_sr_swap;
        end else if (q.QST) begin
            r_ff <= ~w_sr_swap;
        end else if (w_en) begin
            r_ff <= w_d;
        end
    end

    assign q.QZ = w_bypass ? w_d : r_ff;

endmodule
`default_nettype wire

// File: tb/tb_q_frag_regstage.sv
`default_nettype none
// ============================================================================
// tb_q_frag_regstage : scoreboard bench for q_frag_regstage (default mode DUT
//                      plus a second instance with CFG_DEFAULT = 4'b0111).
// Revision           : 1.0
// ============================================================================
module tb_q_frag_regstage;

    typedef struct packed {
        logic [2:0] mask;   // {cfg, alt, main}
        logic       qz;
        logic       alt;
        logic [2:0] cfg;    // {so, rdy, err}
    } exp_t;

    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_ALL  = 3'b111;

    logic clk = 1'b0;
    logic rt, st, en, ds, cz, di;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t  exp_q[$];
    string nm_q[$];
    exp_t  e;
    string nm;

    always #5 clk = ~clk;

    q_frag_regstage_if bus();
    q_frag_regstage_if alt_bus();

    assign bus.QST     = st;
    assign bus.QEN     = en;
    assign bus.QDS     = ds;
    assign bus.CZ      = cz;
    assign bus.QDI     = di;
    assign alt_bus.QST = st;
    assign alt_bus.QEN = en;
    assign alt_bus.QDS = ds;
    assign alt_bus.CZ  = cz;
    assign alt_bus.QDI = di;

`ifdef Q_FRAG_CFG_CHAIN_EN
    logic se, si, ld;
    assign bus.CFG_SE     = se;
    assign bus.CFG_SI     = si;
    assign bus.CFG_LD     = ld;
    assign alt_bus.CFG_SE = 1'b0;
    assign alt_bus.CFG_SI = 1'b0;
    assign alt_bus.CFG_LD = 1'b0;
`endif

    q_frag_regstage #(.CFG_W(4), .CFG_DEFAULT(4'b0000)) dut (
        .QCK (clk),
        .QRT (rt),
        .q   (bus.slave)
    );

    q_frag_regstage #(.CFG_W(4), .CFG_DEFAULT(4'b0111)) dut_alt (
        .QCK (clk),
        .QRT (rt),
        .q   (alt_bus.slave)
    );

    task automatic check(input string n, input string what, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %b, want %b", n, what, act, want);
        end
    endtask

    task automatic drv(input logic rt_v, st_v, en_v, ds_v, cz_v, di_v);
        rt = rt_v; st = st_v; en = en_v; ds = ds_v; cz = cz_v; di = di_v;
    endtask

`ifdef Q_FRAG_CFG_CHAIN_EN
    task automatic cfg(input logic se_v, si_v, ld_v);
        se = se_v; si = si_v; ld = ld_v;
    endtask
`endif

    // Inputs are already driven; queue the state expected after the next edge.
    task automatic cyc(input string n, input logic [2:0] m, input logic eq,
                       input logic ea, input logic [2:0] ec);
        exp_t x;
        x.mask = m; x.qz = eq; x.alt = ea; x.cfg = ec;
        exp_q.push_back(x);
        nm_q.push_back(n);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            if (e.mask[0]) check(nm, "QZ", bus.QZ, e.qz);
            if (e.mask[1]) check(nm, "alt_QZ", alt_bus.QZ, e.alt);
`ifdef Q_FRAG_CFG_CHAIN_EN
            if (e.mask[2]) begin
                check(nm, "CFG_SO",  bus.CFG_SO,  e.cfg[2]);
                check(nm, "CFG_RDY", bus.CFG_RDY, e.cfg[1]);
                check(nm, "CFG_ERR", bus.CFG_ERR, e.cfg[0]);
            end
            if (e.mask[1]) begin
                check(nm, "alt_cfg", alt_bus.CFG_SO | alt_bus.CFG_RDY | alt_bus.CFG_ERR, 1'b0);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef Q_FRAG_CFG_CHAIN_EN
        cfg(0, 0, 0);
`endif
        // Reset, default mode, set/reset priority, data select
        drv(1, 0, 1, 0, 1, 0); cyc("rst_first",   M_NONE, 0, 0, 3'b000);
                               cyc("rst_hold",    M_ALL,  0, 1, 3'b000);
        drv(0, 0, 1, 0, 1, 0); cyc("load_cz",     M_ALL,  1, 1, 3'b000);
        drv(0, 0, 0, 0, 0, 0); cyc("hold",        M_ALL,  1, 0, 3'b000);
        drv(1, 1, 1, 0, 0, 0); cyc("rt_over_st",  M_ALL,  0, 1, 3'b000);
        drv(0, 1, 1, 0, 0, 0); cyc("set",         M_ALL,  1, 0, 3'b000);
        drv(0, 0, 0, 0, 0, 1); cyc("en_off",      M_ALL,  1, 1, 3'b000);
        drv(0, 0, 1, 1, 1, 0); cyc("qds_qdi",     M_ALL,  0, 1, 3'b000);

`ifdef Q_FRAG_CFG_CHAIN_EN
        // Load 4'b1010 (EN_INV + BYPASS)
        drv(0, 0, 0, 0, 0, 0);
        cfg(1, 1, 0); cyc("sh1",     M_ALL, 0, 0, 3'b000);
        cfg(1, 0, 0); cyc("sh2",     M_ALL, 0, 0, 3'b000);
        cfg(1, 1, 0); cyc("sh3",     M_ALL, 0, 0, 3'b000);
        cfg(1, 0, 0); cyc("sh4_rdy", M_ALL, 0, 0, 3'b110);
        drv(0, 0, 0, 0, 1, 0); cfg(0, 0, 1); cyc("ld_byp",  M_ALL, 1, 0, 3'b100);
        cfg(0, 0, 0);
        drv(0, 0, 1, 0, 0, 1); cyc("byp_cz0", M_ALL, 0, 0, 3'b100);
        drv(0, 0, 1, 1, 0, 1); cyc("byp_qdi", M_ALL, 1, 0, 3'b100);
        drv(0, 0, 1, 0, 1, 0); cyc("byp_cz1", M_ALL, 1, 0, 3'b100);

        // Early load rejected, then 4'b0010 (EN_INV only) accepted
        cfg(1, 0, 0); cyc("e_sh1",    M_ALL, 1, 0, 3'b000);
        cfg(1, 0, 0); cyc("e_sh2",    M_ALL, 1, 0, 3'b100);
        cfg(0, 0, 1); cyc("early_ld", M_ALL, 1, 0, 3'b101);
        cfg(1, 1, 0); cyc("e_sh3",    M_ALL, 1, 0, 3'b001);
        cfg(1, 0, 0); cyc("e_sh4",    M_ALL, 1, 0, 3'b011);
        cfg(0, 0, 1); cyc("late_ld",  M_ALL, 0, 0, 3'b001);
        cfg(0, 0, 0);
        drv(0, 0, 0, 0, 1, 0); cyc("en_inv_ld",   M_ALL, 1, 0, 3'b001);
        drv(0, 0, 1, 0, 0, 0); cyc("en_inv_hold", M_ALL, 1, 0, 3'b001);

        // 4 shifts of 4'b0001, then shift+load together
        cfg(1, 0, 0); cyc("s_sh1", M_ALL, 1, 0, 3'b001);
        cfg(1, 0, 0); cyc("s_sh2", M_ALL, 1, 0, 3'b101);
        cfg(1, 0, 0); cyc("s_sh3", M_ALL, 1, 0, 3'b001);
        cfg(1, 1, 0); cyc("s_sh4", M_ALL, 1, 0, 3'b011);
        cfg(1, 1, 1); cyc("sh_ld", M_ALL, 1, 0, 3'b001);
        cfg(0, 0, 0);
        drv(0, 0, 1, 0, 1, 0); cyc("force_qdi", M_ALL, 0, 0, 3'b001);
        // shadow 0011 / count 1: two shifts expose the 1s, third reaches full
        cfg(1, 0, 0); cyc("post_sh1", M_ALL, 0, 0, 3'b001);
        cfg(1, 0, 0); cyc("post_sh2", M_ALL, 0, 0, 3'b101);
        cfg(1, 0, 0); cyc("post_sh3", M_ALL, 0, 0, 3'b111);

        // SR_SWAP mode 4'b0100
        cfg(1, 0, 0); cyc("w_sh1", M_ALL, 0, 0, 3'b011);
        cfg(1, 1, 0); cyc("w_sh2", M_ALL, 0, 0, 3'b011);
        cfg(1, 0, 0); cyc("w_sh3", M_ALL, 0, 0, 3'b011);
        cfg(1, 0, 0); cyc("w_sh4", M_ALL, 0, 0, 3'b011);
        drv(0, 0, 1, 0, 1, 1); cfg(0, 0, 1); cyc("swap_ld", M_ALL, 1, 0, 3'b001);
        cfg(0, 0, 0);
        drv(0, 1, 1, 0, 1, 1); cyc("swap_set",  M_ALL, 0, 0, 3'b001);
        drv(1, 0, 1, 0, 1, 1); cyc("swap_rst",  M_ALL, 1, 1, 3'b000);
        drv(0, 0, 0, 0, 1, 1); cyc("dflt_hold", M_ALL, 1, 1, 3'b000);
`endif

        drv(1, 0, 1, 0, 1, 1); cyc("rst_final", M_ALL, 0, 1, 3'b000);
        drv(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
